io_port_unit: RTL and testbench
===============================

# io_port_unit

- Processor-side responder for the IN/OUT instructions. It sits beside the memory/write-back boundary and receives the In/Out control bits and 16-bit data that the pipeline carries to write-back.
- OUT data goes into an output FIFO. The FIFO drains to the outside world over a valid/ready channel.
- IN requests are served from a one-entry receive holding register, which is filled from an inbound valid/ready channel.
- When the requested transfer cannot complete this cycle, `stall` is raised to freeze the pipeline.

## Interface
Parameters:
- `DEPTH`, 4: output FIFO entries; power of two, at least 2.
- `WIDTH`, 16: data width; equals the processor word.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low; sampled on the `clk` rising edge.
- `out_en`  in  1  OUT instruction present this cycle.
- `out_data`  in  WIDTH  register value to emit.
- `in_en`  in  1  IN instruction present this cycle.
- `in_data`  out  WIDTH  value returned to write-back.
- `stall`  out  1  pipeline freeze request.
- `tx_valid`  out  1  outbound word available.
- `tx_data`  out  WIDTH  outbound word, the FIFO head.
- `tx_ready`  in  1  external sink accepts the word.
- `rx_valid`  in  1  external source offers a word.
- `rx_data`  in  WIDTH  inbound word.
- `rx_ready`  out  1  holding register can accept a word.

## Operation
- Output FIFO:
  - Circular buffer with read and write pointers of width log2(DEPTH) that wrap modulo DEPTH.
  - A count from 0 to DEPTH gives `full` (count == DEPTH) and `empty` (count == 0).
- Pop:
  - Occurs when `tx_valid && tx_ready`.
  - `tx_valid` = !empty.
  - `tx_data` = mem[rd_ptr].
- Blocking conditions:
  - `out_block` = `out_en && full`.
  - `in_block` = `in_en && !rx_full`.
  - `stall` = `out_block || in_block`.
- Commit:
  - Both OUT and IN commit only in a cycle where `stall` == 0. The commit is atomic when both are asserted.
  - OUT commit pushes `out_data`.
  - IN commit clears `rx_full`.
- `in_data` = rx_buf when `in_en && rx_full`, otherwise 0.
- Receive side:
  - `rx_ready` = !rx_full, forced to 0 while reset is asserted.
  - A word is captured into rx_buf on `rx_valid && rx_ready`, which sets `rx_full`.
  - An IN commit and a capture never coincide, because capture requires !rx_full.
- FSM with states IDLE, OUT_WAIT and IN_WAIT. The state is registered and used for the stall-reason status only.
  - IDLE -> OUT_WAIT when out_block.
  - IDLE -> IN_WAIT when in_block and not out_block.
  - Either wait state -> IDLE in the first cycle in which `stall` == 0.
  - OUT_WAIT -> IN_WAIT when out_block clears while in_block persists.
- Full FIFO with simultaneous pop and pending OUT: still stalls that cycle. There is no push-through-pop bypass, so the push lands the next cycle.
- Empty FIFO: a push and a pop in the same cycle is impossible, since `tx_valid` is 0.
- Reset mid-operation:
  - FIFO contents are discarded: pointers and count go to 0.
  - `rx_full` = 0 and the state goes to IDLE.
  - A word in flight on tx is dropped.

## Timing
- Reset values: `tx_valid` 0, `rx_ready` 0 during reset and 1 after, `stall` 0, `in_data` 0, `tx_data` undefined (don't-care).
- OUT latency: push at edge N puts the word on `tx_data` with `tx_valid` = 1 from cycle N+1.
- IN latency:
  - rx captured at edge N makes `in_data` valid and `stall` low from cycle N+1.
  - With the register already full, IN completes in 0 extra cycles.
- `stall` is combinational from inputs and registered flags in the same cycle.
- The processor holds `out_en`, `out_data` and `in_en` stable while `stall` = 1.
- `tx_data` is stable while `tx_valid && !tx_ready`.
- Throughput: one OUT per cycle while the FIFO is not full, and one tx pop per cycle.

## Configuration
- `IO_PORT_COUNT_EN`:
  - Defined: adds outputs `out_count` and `in_count`, each 16 bits and registered.
  - `out_count` increments on each OUT commit; `in_count` increments on each IN commit.
  - Both wrap 0xFFFF -> 0 and reset to 0.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Package `io_pkg`:
  - `IO_WIDTH` = 16.
  - State typedef `io_state_t` with values IDLE, OUT_WAIT, IN_WAIT.
  - Default `IO_DEPTH` = 4.
- Sub-module `io_out_fifo`:
  - Handles push, pop, full, empty, head and count.
  - Parameterised by DEPTH and WIDTH.
  - Contains no stall logic.

## Test plan
- Reset held 2 cycles, then released: all outputs at reset values; `rx_ready` rises to 1 in the first cycle after release.
- OUT 0x1234 with `tx_ready` = 1: `tx_valid` = 1 and `tx_data` = 0x1234 the next cycle, then empty again a cycle later; `stall` never asserts.
- Five OUTs (0x0001–0x0005) with `tx_ready` = 0 and DEPTH 4:
  - The fifth OUT raises `stall`.
  - Raising `tx_ready` pops 0x0001; the fifth push lands one cycle later.
  - Order out is 0x0001–0x0005.
- IN with an empty holding register: `stall` = 1 until `rx_valid` with 0xBEEF. The next cycle gives `stall` = 0, `in_data` = 0xBEEF, and `rx_ready` returns to 1 after the commit.
- OUT and IN together with a full FIFO and empty rx: `stall` stays 1 until both are resolved, and both commit in the same cycle.
- Reset asserted with 3 words queued and `rx_full` set: FIFO empty, `tx_valid` 0 and `rx_ready` 0 on the next edge. With `IO_PORT_COUNT_EN` defined, the counters return to 0.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants and state type for the IN/OUT port responder.
package io_pkg;

    localparam int IO_WIDTH = 16;
    localparam int IO_DEPTH = 4;

    // Numeric state codes, kept stable so the stall-reason status keeps its encoding.
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_OUT_WAIT = 2'd1;
    localparam logic [1:0] ST_IN_WAIT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        OUT_WAIT = ST_OUT_WAIT,
        IN_WAIT  = ST_IN_WAIT
    } io_state_t;

endpackage

// File: rtl/io_out_fifo.sv
// Output FIFO for OUT data: circular buffer with wrapping pointers and an
// occupancy count. Contains no stall logic; callers gate push on !full.
module io_out_fifo
    import io_pkg::*;
#(
    parameter int DEPTH = IO_DEPTH,
    parameter int WIDTH = IO_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage is not reset; empty/count make stale contents invisible.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/io_port_unit.sv
// Processor-side IN/OUT responder: OUT words queue into a FIFO drained over
// tx valid/ready; IN reads a one-entry holding register filled over rx
// valid/ready. Stalls the pipeline when a transfer cannot complete.
// Optional build macro IO_PORT_COUNT_EN adds OUT/IN commit counters.
//
// State    | meaning
// IDLE     | no stall pending
// OUT_WAIT | stalled on a full output FIFO
// IN_WAIT  | stalled waiting for an inbound word
module io_port_unit
    import io_pkg::*;
#(
    parameter int DEPTH = IO_DEPTH,
    parameter int WIDTH = IO_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             out_en,
    input  logic [WIDTH-1:0] out_data,
    input  logic             in_en,
    output logic [WIDTH-1:0] in_data,
    output logic             stall,
    output logic             tx_valid,
    output logic [WIDTH-1:0] tx_data,
    input  logic             tx_ready,
    input  logic             rx_valid,
    input  logic [WIDTH-1:0] rx_data,
    output logic             rx_ready,
    output logic [1:0]       stall_reason
`ifdef IO_PORT_COUNT_EN
    ,
    output logic [15:0]      out_count,
    output logic [15:0]      in_count
`endif
);

    logic             w_full;
    logic             w_empty;
    logic             w_out_block;
    logic             w_in_block;
    logic             w_out_commit;
    logic             w_in_commit;
    logic             r_rx_full;
    logic [WIDTH-1:0] r_rx_buf;
    io_state_t        r_state;

    assign w_out_block  = out_en && w_full;
    assign w_in_block   = in_en && !r_rx_full;
    assign stall        = w_out_block || w_in_block;
    assign w_out_commit = out_en && !stall;
    assign w_in_commit  = in_en && !stall;
    assign tx_valid     = !w_empty;
    assign rx_ready     = reset && !r_rx_full;
    assign in_data      = (in_en && r_rx_full) ? r_rx_buf : '0;
    assign stall_reason = r_state;

    io_out_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_out_fifo (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_push  (w_out_commit),
        .i_wdata (out_data),
        .i_pop   (tx_valid && tx_ready),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (tx_data)
    );

    // Receive holding register: capture needs !rx_full, so it never meets an IN commit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_full <= 1'b0;
        end else if (rx_valid && rx_ready) begin
            r_rx_full <= 1'b1;
        end else if (w_in_commit) begin
            r_rx_full <= 1'b0;
        end
    end

    // Data half of the holding register needs no reset; rx_full qualifies it.
    always_ff @(posedge clk) begin
        if (rx_valid && rx_ready) begin
            r_rx_buf <= rx_data;
        end
    end

    // Stall-reason tracking; does not feed back into stall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_out_block) begin
                        r_state <= OUT_WAIT;
                    end else if (w_in_block) begin
                        r_state <= IN_WAIT;
                    end
                end
                OUT_WAIT: begin
                    if (!stall) begin
                        r_state <= IDLE;
                    end else if (!w_out_block) begin
                        r_state <= IN_WAIT;
                    end
                end
                IN_WAIT: begin
                    if (!stall) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef IO_PORT_COUNT_EN
    logic [15:0] r_out_count;
    logic [15:0] r_in_count;

    assign out_count = r_out_count;
    assign in_count  = r_in_count;

    // Commit counters, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_count <= '0;
            r_in_count  <= '0;
        end else begin
            if (w_out_commit) begin
                r_out_count <= r_out_count + 16'd1;
            end
            if (w_in_commit) begin
                r_in_count <= r_in_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_io_port_unit.sv
// Directed bench for io_port_unit; counter checks apply when IO_PORT_COUNT_EN is defined.
module tb_io_port_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        out_en;
    logic [15:0] out_data;
    logic        in_en;
    logic [15:0] in_data;
    logic        stall;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic        rx_ready;
    logic [1:0]  stall_reason;
`ifdef IO_PORT_COUNT_EN
    logic [15:0] out_count;
    logic [15:0] in_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    io_port_unit #(.DEPTH(4), .WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .out_en       (out_en),
        .out_data     (out_data),
        .in_en        (in_en),
        .in_data      (in_data),
        .stall        (stall),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .stall_reason (stall_reason)
`ifdef IO_PORT_COUNT_EN
        ,
        .out_count    (out_count),
        .in_count     (in_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        out_en   = 1'b0;
        out_data = '0;
        in_en    = 1'b0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;

        // Reset held two cycles
        step();
        step();
        check("rst_tx_valid", tx_valid, 0);
        check("rst_rx_ready", rx_ready, 0);
        check("rst_stall", stall, 0);
        check("rst_in_data", in_data, 0);
        check("rst_reason", stall_reason, 0);
        reset = 1'b1;
        settle();
        check("rel_rx_ready", rx_ready, 1);
        step();
        check("rel_rx_ready2", rx_ready, 1);

        // Single OUT with sink ready
        tx_ready = 1'b1;
        out_en   = 1'b1;
        out_data = 16'h1234;
        settle();
        check("out1_stall", stall, 0);
        check("out1_pre_valid", tx_valid, 0);
        step();
        out_en = 1'b0;
        settle();
        check("out1_valid", tx_valid, 1);
        check("out1_data", tx_data, 16'h1234);
        check("out1_stall2", stall, 0);
        step();
        check("out1_empty", tx_valid, 0);

        // Five OUTs into a depth-4 FIFO with sink blocked
        tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            out_en   = 1'b1;
            out_data = 16'(i);
            settle();
            check("fill_stall", stall, 0);
            step();
        end
        out_data = 16'h0005;
        settle();
        check("fifth_stall", stall, 1);
        check("fifth_head", tx_data, 16'h0001);
        step();
        check("fifth_stall_hold", stall, 1);
        check("fifth_reason", stall_reason, 1);
        tx_ready = 1'b1;
        settle();
        check("no_bypass_stall", stall, 1);
        step();
        check("after_pop_stall", stall, 0);
        check("order_2", tx_data, 16'h0002);
        check("reason_still_out", stall_reason, 1);
        step();
        out_en = 1'b0;
        settle();
        check("reason_idle", stall_reason, 0);
        for (int i = 3; i <= 5; i++) begin
            check("order_n", {tx_valid, 15'd0, tx_data}, {1'b1, 15'd0, 16'(i)});
            step();
        end
        check("drain_empty", tx_valid, 0);
        tx_ready = 1'b0;

        // IN with empty holding register
        in_en = 1'b1;
        settle();
        check("in_stall", stall, 1);
        check("in_data_zero", in_data, 0);
        step();
        check("in_stall_hold", stall, 1);
        check("in_reason", stall_reason, 2);
        rx_valid = 1'b1;
        rx_data  = 16'hBEEF;
        settle();
        check("in_rx_ready", rx_ready, 1);
        step();
        rx_valid = 1'b0;
        settle();
        check("in_unstall", stall, 0);
        check("in_data_beef", in_data, 16'hBEEF);
        check("in_rx_busy", rx_ready, 0);
        step();
        in_en = 1'b0;
        settle();
        check("in_rx_ready_back", rx_ready, 1);
        check("in_data_off", in_data, 0);
        check("in_reason_idle", stall_reason, 0);

        // IN with holding register already full: zero extra cycles
        rx_valid = 1'b1;
        rx_data  = 16'h5A5A;
        step();
        rx_valid = 1'b0;
        settle();
        check("pre_full_rx_ready", rx_ready, 0);
        in_en = 1'b1;
        settle();
        check("pre_full_stall", stall, 0);
        check("pre_full_data", in_data, 16'h5A5A);
        step();
        in_en = 1'b0;
        settle();
        check("pre_full_clear", rx_ready, 1);

        // OUT and IN together: full FIFO and empty rx
        for (int i = 0; i < 4; i++) begin
            out_en   = 1'b1;
            out_data = 16'hA0 + 16'(i);
            step();
        end
        out_data = 16'h00A4;
        in_en    = 1'b1;
        settle();
        check("both_stall", stall, 1);
        step();
        check("both_reason_out", stall_reason, 1);
        tx_ready = 1'b1;
        settle();
        check("both_stall_pop", stall, 1);
        step();
        tx_ready = 1'b0;
        settle();
        check("both_stall_in", stall, 1);
        step();
        check("both_reason_in", stall_reason, 2);
        rx_valid = 1'b1;
        rx_data  = 16'hC0DE;
        step();
        rx_valid = 1'b0;
        settle();
        check("both_unstall", stall, 0);
        check("both_in_data", in_data, 16'hC0DE);
        step();
        out_en = 1'b0;
        in_en  = 1'b0;
        settle();
        check("both_rx_cleared", rx_ready, 1);
        tx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("both_order", {tx_valid, 15'd0, tx_data}, {1'b1, 15'd0, 16'hA0 + 16'(i)});
            step();
        end
        check("both_drained", tx_valid, 0);
        tx_ready = 1'b0;

        // Reset mid-operation with queued words and full rx
        for (int i = 0; i < 3; i++) begin
            out_en   = 1'b1;
            out_data = 16'h0300 + 16'(i);
            step();
        end
        out_en   = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 16'h1111;
        step();
        rx_valid = 1'b0;
        settle();
        check("pre_rst_valid", tx_valid, 1);
        check("pre_rst_rx_full", rx_ready, 0);
`ifdef IO_PORT_COUNT_EN
        check("pre_rst_out_count", out_count, 14);
        check("pre_rst_in_count", in_count, 3);
`endif
        reset    = 1'b0;
        tx_ready = 1'b1;
        settle();
        check("mid_rst_rx_ready", rx_ready, 0);
        step();
        check("mid_rst_valid", tx_valid, 0);
        check("mid_rst_stall", stall, 0);
        check("mid_rst_rx_ready2", rx_ready, 0);
`ifdef IO_PORT_COUNT_EN
        check("mid_rst_out_count", out_count, 0);
        check("mid_rst_in_count", in_count, 0);
`endif
        reset = 1'b1;
        settle();
        check("post_rst_rx_ready", rx_ready, 1);
        check("post_rst_empty", tx_valid, 0);
        out_en   = 1'b1;
        out_data = 16'h7777;
        step();
        out_en = 1'b0;
        settle();
        check("post_rst_out", tx_data, 16'h7777);
        check("post_rst_valid", tx_valid, 1);
        step();
        check("post_rst_drained", tx_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
